// File: rtl/ws2812_frame_ctrl_if.sv
// Frame-controller bus: start/busy/done handshake, pixel read port and serial line.
// master = frame source / pixel store side, slave = ws2812_frame_ctrl.
interface ws2812_frame_ctrl_if #(
  parameter int AW = 6
);
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic          dout;

  modport master (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, dout
  );

  modport slave (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, dout
  );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame serializer: fetches NUM_LEDS GRB pixels and shifts them out MSB first.
// Define WS2812_AUTO_REFRESH_EN to loop frames continuously after the first start.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS = 64,
  parameter int AW       = 6,
  parameter int T0H      = 16,
  parameter int T1H      = 32,
  parameter int TBIT     = 50,
  parameter int TRST     = 2000
) (
  input  logic             clk,
  input  logic             rstn,
  ws2812_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, BIT_HI, BIT_LO, LATCH, DONE
  } state_e;

  localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  // Terminal counts: every phase counts 0..len-1 so its length is exact.
  localparam logic [CW-1:0] HI0_END  = CW'(T0H - 1);
  localparam logic [CW-1:0] HI1_END  = CW'(T1H - 1);
  localparam logic [CW-1:0] LO0_END  = CW'(TBIT - T0H - 1);
  localparam logic [CW-1:0] LO1_END  = CW'(TBIT - T1H - 1);
  localparam logic [CW-1:0] RST_END  = CW'(TRST - 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(NUM_LEDS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [23:0]   buf_q, buf_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        buf_d   = bus.rd_data;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = BIT_HI;
      end
      BIT_HI: begin
        if (cnt_q == (buf_q[23] ? HI1_END : HI0_END)) begin
          cnt_d   = '0;
          state_d = BIT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_LO: begin
        // Low length still keys off the current MSB; the shift lands at the bit boundary.
        if (cnt_q == (buf_q[23] ? LO1_END : LO0_END)) begin
          cnt_d = '0;
          buf_d = {buf_q[22:0], 1'b0};
          if (bit_q == 5'd23) begin
            if (pix_q == LAST_PIX) begin
              state_d = LATCH;
            end else begin
              pix_d   = pix_q + AW'(1);
              state_d = FETCH;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            state_d = BIT_HI;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == RST_END) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        pix_d = '0;
`ifdef WS2812_AUTO_REFRESH_EN
        state_d = FETCH;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout    = (state_q == BIT_HI);
  assign bus.rd_en   = (state_q == FETCH);
  assign bus.rd_addr = pix_q;
  assign bus.done    = (state_q == DONE);
`ifdef WS2812_AUTO_REFRESH_EN
  assign bus.busy    = (state_q != IDLE);
`else
  assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Randomized bench for ws2812_frame_ctrl: per-cycle dout/busy/rd_en capture compared
// against a waveform built directly from pixel values and bit timing.
module tb_ws2812_frame_ctrl;
  localparam int NL    = 3;
  localparam int AW    = 2;
  localparam int T0H   = 16;
  localparam int T1H   = 32;
  localparam int TBIT  = 50;
  localparam int TRST  = 2000;
  localparam int PIXC  = 2 + 24 * TBIT;
  localparam int FRAME = NL * PIXC + TRST + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  ws2812_frame_ctrl_if #(.AW(AW)) bus();

  ws2812_frame_ctrl #(
    .NUM_LEDS(NL), .AW(AW), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [NL];

  // Pixel store: data valid only the cycle after rd_en, noise otherwise.
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? mem[int'(bus.rd_addr) % NL] : 24'($urandom);

  int checks = 0;
  int errors = 0;

  bit dq[$];
  bit bq[$];
  bit rq[$];
  int aq[$];
  bit eq[$];
  int ew[$];

  // Record one frame from the FETCH cycle until done (inclusive), bounded.
  task automatic collect(input bit hold, input int poke, output int len);
    dq.delete(); bq.delete(); rq.delete(); aq.delete();
    len = 0;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(negedge clk);
      dq.push_back(bus.dout);
      bq.push_back(bus.busy);
      rq.push_back(bus.rd_en);
      if (bus.rd_en) aq.push_back(int'(bus.rd_addr));
      bus.start = hold || (i == poke);
      len = i + 1;
      if (bus.done) break;
    end
    if (!hold) bus.start = 1'b0;
  endtask

  // Reference waveform: 2 idle-low cycles per pixel, 24 MSB-first bits, latch, done.
  task automatic build_expected();
    int hi;
    eq.delete(); ew.delete();
    for (int p = 0; p < NL; p++) begin
      eq.push_back(1'b0); eq.push_back(1'b0);
      for (int b = 23; b >= 0; b--) begin
        hi = mem[p][b] ? T1H : T0H;
        ew.push_back(hi);
        for (int k = 0; k < TBIT; k++) eq.push_back(k < hi);
      end
    end
    for (int k = 0; k < TRST + 1; k++) eq.push_back(1'b0);
  endtask

  task automatic analyze(output int wave_err, output int width_err,
                         output int busy_err, output int addr_err, output int nrd);
    int run;
    int aw[$];
    build_expected();
    wave_err = -1;
    for (int i = 0; i < dq.size() && i < eq.size(); i++)
      if (wave_err < 0 && dq[i] != eq[i]) wave_err = i;
    if (wave_err < 0 && dq.size() != eq.size())
      wave_err = (dq.size() < eq.size()) ? dq.size() : eq.size();
    run = 0;
    for (int i = 0; i < dq.size(); i++) begin
      if (dq[i]) run++;
      else if (run > 0) begin aw.push_back(run); run = 0; end
    end
    if (run > 0) aw.push_back(run);
    width_err = (aw.size() != ew.size()) ? 1000 : -1;
    for (int i = 0; i < aw.size() && i < ew.size(); i++)
      if (width_err < 0 && aw[i] != ew[i]) width_err = i;
    busy_err = -1;
    for (int i = 0; i < bq.size(); i++)
      if (busy_err < 0 && bq[i] != (i != bq.size() - 1)) busy_err = i;
    addr_err = (aq.size() != NL) ? 1 : 0;
    for (int i = 0; i < aq.size(); i++) if (aq[i] != i) addr_err = 1;
    nrd = 0;
    foreach (rq[i]) nrd += int'(rq[i]);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.dout, bus.rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b dout=%b addr=%0d want all 0",
               bus.busy, bus.done, bus.rd_en, bus.dout, bus.rd_addr);
    end
    bus.start = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (!(bus.rd_en === 1'b1 && bus.rd_addr === '0 && bus.busy === 1'b1)) begin
      errors++;
      $display("FAIL first_start got rd_en=%b addr=%0d busy=%b want 1 0 1",
               bus.rd_en, bus.rd_addr, bus.busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.dout, bus.rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_in_fetch got busy=%b rd_en=%b addr=%0d want 0",
               bus.busy, bus.rd_en, bus.rd_addr);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_frame_random();
    int len, we, wd, be, ae, nrd, stray;
    foreach (mem[i]) mem[i] = 24'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    collect(1'b0, 100 + int'($urandom_range(0, 4000)), len);
    analyze(we, wd, be, ae, nrd);
    checks++;
    if (len != FRAME) begin errors++; $display("FAIL rand_len got %0d want %0d", len, FRAME); end
    checks++;
    if (we != -1) begin errors++; $display("FAIL rand_wave first diff at cycle %0d want none", we); end
    checks++;
    if (nrd != NL) begin errors++; $display("FAIL rand_rd_en got %0d pulses want %0d", nrd, NL); end
    checks++;
    if (ae != 0) begin errors++; $display("FAIL rand_addr_seq got %0d addrs want 0..%0d", aq.size(), NL - 1); end
    checks++;
    if (be != -1) begin errors++; $display("FAIL rand_busy wrong at cycle %0d want none", be); end
    // A start poked mid-frame must not launch a second frame.
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stray += int'(bus.busy) + int'(bus.rd_en) + int'(bus.done);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL no_queue got %0d active cycles want 0", stray); end
  endtask

  task automatic test_patterns();
    int len, we, wd, be, ae, nrd;
    mem[0] = 24'h000000;
    mem[1] = 24'hFFFFFF;
    mem[2] = 24'hE15F10;
    @(negedge clk);
    bus.start = 1'b1;
    collect(1'b0, -1, len);
    analyze(we, wd, be, ae, nrd);
    checks++;
    if (wd != -1) begin errors++; $display("FAIL pattern_widths first bad run %0d want none", wd); end
    checks++;
    if (we != -1) begin errors++; $display("FAIL pattern_wave first diff at cycle %0d want none", we); end
    checks++;
    if (len != FRAME) begin errors++; $display("FAIL pattern_len got %0d want %0d", len, FRAME); end
  endtask

  task automatic test_start_held();
    int len, we, wd, be, ae, nrd;
    foreach (mem[i]) mem[i] = 24'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    collect(1'b1, -1, len);
    analyze(we, wd, be, ae, nrd);
    checks++;
    if (len != FRAME || nrd != NL) begin
      errors++;
      $display("FAIL held_frame got len=%0d rd=%0d want %0d %0d", len, nrd, FRAME, NL);
    end
    checks++;
    if (we != -1) begin errors++; $display("FAIL held_wave first diff at cycle %0d want none", we); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_gap got busy=%b rd_en=%b want 0 0", bus.busy, bus.rd_en);
    end
    @(negedge clk);
    checks++;
    if (!(bus.rd_en === 1'b1 && bus.rd_addr === '0 && bus.busy === 1'b1)) begin
      errors++;
      $display("FAIL held_restart got rd_en=%b addr=%0d busy=%b want 1 0 1",
               bus.rd_en, bus.rd_addr, bus.busy);
    end
    bus.start = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset_abort();
    int len, we, wd, be, ae, nrd, stray, ab;
    foreach (mem[i]) mem[i] = 24'($urandom);
    build_expected();
    ab = PIXC + 2 + 10 * TBIT + 5;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i <= ab; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.dout !== eq[ab] || bus.busy !== 1'b1 || bus.rd_addr !== AW'(1)) begin
      errors++;
      $display("FAIL abort_pre got dout=%b busy=%b addr=%0d want %b 1 1",
               bus.dout, bus.busy, bus.rd_addr, eq[ab]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.dout, bus.busy, bus.rd_en, bus.done, bus.rd_addr} !== '0) begin
      errors++;
      $display("FAIL abort_immediate got dout=%b busy=%b rd_en=%b addr=%0d want 0",
               bus.dout, bus.busy, bus.rd_en, bus.rd_addr);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      stray += int'(bus.done) + int'(bus.busy) + int'(bus.rd_en);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", stray); end
    bus.start = 1'b1;
    collect(1'b0, -1, len);
    analyze(we, wd, be, ae, nrd);
    checks++;
    if (ae != 0) begin errors++; $display("FAIL abort_restart_addr got %0d addrs first=%0d want 0..%0d", aq.size(), (aq.size() > 0) ? aq[0] : -1, NL - 1); end
    checks++;
    if (we != -1 || len != FRAME) begin
      errors++;
      $display("FAIL abort_restart_frame got diff=%0d len=%0d want none %0d", we, len, FRAME);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_frame_random();
    test_patterns();
    test_start_held();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_ctrl.md
WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 64: pixels per frame, legal range 1..2^AW.
REQ-002 SHALL have parameter AW, default 6: pixel address width.
REQ-003 SHALL have parameter T0H, default 16: high cycles for a 0 bit.
REQ-004 SHALL have parameter T1H, default 32: high cycles for a 1 bit.
REQ-005 SHALL have parameter TBIT, default 50: total cycles per bit; T0H < T1H < TBIT is required.
REQ-006 SHALL have parameter TRST, default 2000: latch (reset) low cycles after a frame.
REQ-007 SHALL have port clk  input  1: sole clock, rising edge.
REQ-008 SHALL have port rstn  input  1: asynchronous active-low reset.
REQ-009 SHALL have port start  input  1: frame request, sampled only in IDLE.
REQ-010 SHALL have port busy  output  1: high from the cycle after accepted start until the DONE cycle, exclusive.
REQ-011 SHALL have port done  output  1: one-cycle pulse at frame completion.
REQ-012 SHALL have port rd_en  output  1: pixel read strobe.
REQ-013 SHALL have port rd_addr  output  AW: pixel index, 0..NUM_LEDS-1.
REQ-014 SHALL have port rd_data  input  24: GRB pixel, valid exactly one cycle after rd_en.
REQ-015 SHALL have port dout  output  1: serial line to the LED chain.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, BIT_HI, BIT_LO, LATCH, DONE.
REQ-017 IDLE with start=1 SHALL go to FETCH next cycle; start=0 stays in IDLE.
REQ-018 FETCH SHALL last 1 cycle with rd_en=1 and rd_addr=current pixel index, then go to LOAD.
REQ-019 LOAD SHALL capture rd_data into a 24-bit shift buffer, clear the bit counter, and go to BIT_HI.
REQ-020 BIT_HI SHALL drive dout=1 for T0H cycles if buffer MSB=0, or T1H cycles if MSB=1.
REQ-021 BIT_LO SHALL drive dout=0 for TBIT-T0H or TBIT-T1H cycles, so each bit is exactly TBIT cycles.
REQ-022 Bits SHALL be sent MSB first, 24 per pixel, with the buffer shifted left by 1 at the end of each BIT_LO.
REQ-023 After bit 23: if the pixel index is < NUM_LEDS-1, it SHALL increment and go to FETCH (2 extra dout=0 cycles between pixels); otherwise SHALL go to LATCH.
REQ-024 LATCH SHALL hold dout=0 for exactly TRST cycles, then go to DONE.
REQ-025 DONE SHALL last 1 cycle with done=1 and busy=0, reset the pixel index to 0, and return to IDLE.
REQ-026 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 rd_en SHALL be 0 and dout 0 in every state except those stated above.
REQ-028 Cycle counters SHALL be sized by $clog2 of the largest of TBIT and TRST; the pixel index SHALL be AW bits and SHALL never exceed NUM_LEDS-1.
REQ-029 Frame length SHALL be exactly 2 + NUM_LEDS*(2+24*TBIT) - 2 + TRST + 1 cycles from FETCH entry to DONE inclusive.

Reset
REQ-030 rstn=0 SHALL immediately force the state to IDLE, dout=0, busy=0, done=0, rd_en=0, rd_addr=0, and all counters and the buffer to 0.
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse; the next start SHALL begin at pixel 0.
REQ-032 The first start is accepted on the first rising clk edge after rstn deasserts.

Configuration
REQ-033 With macro WS2812_AUTO_REFRESH_EN defined, DONE SHALL return to FETCH (pixel 0) instead of IDLE, so frames repeat continuously after the first start; done still pulses, busy stays 1 throughout, and start is ignored.
REQ-034 Without WS2812_AUTO_REFRESH_EN, behaviour SHALL be exactly per REQ-025.

Verification
REQ-035 NUM_LEDS=1, rd_data=24'hE15F10, one start pulse -> dout has 24 bits with high widths of 32/16 cycles matching 1110_0001_0101_1111_0001_0000, each bit period 50 cycles, then 2000 low cycles, then done for 1 cycle.
REQ-036 NUM_LEDS=3 -> rd_addr sequence is 0,1,2 with exactly 3 rd_en pulses; there are 2 low cycles between pixels; done arrives 3*1202-2+2000+3 cycles after start.
REQ-037 start held high continuously -> exactly one frame per IDLE visit; no start is accepted while busy=1.
REQ-038 rstn pulsed low during pixel 1 bit 10 -> dout, busy and rd_en are 0 immediately; a new start fetches address 0; no done pulse is seen for the aborted frame.
REQ-039 rd_data=24'h000000 and 24'hFFFFFF -> all high widths are 16 and 32 cycles respectively.
REQ-040 With WS2812_AUTO_REFRESH_EN and one start -> consecutive frames separated only by DONE, one done pulse per frame, busy never drops.
